cp0_unit: RTL and testbench

Coprocessor-0 for the pipelined MIPS core: collects exception codes raised upstream (address errors on load/store, arithmetic overflow, reserved instruction) plus six hardware interrupt lines, and decides whether the pipeline must flush and jump to the handler. Records the victim PC, the cause and the delay-slot flag. Serves `mfc0`/`mtc0`/`eret` from the M stage. Sits beside the M-stage pipeline register and drives the flush/redirect logic in the PC unit.

---
 rtl/cp0_unit.sv | 110 +++++++++++
 tb/tb_cp0_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// Coprocessor 0: exception/interrupt arbitration, SR/Cause/EPC/PRId registers,
// and the mfc0/mtc0/eret datapath serving the M stage.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2020
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        we,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC_out,
    output logic [31:0] DOut
);

    localparam logic [4:0] RegSr    = 5'd12;
    localparam logic [4:0] RegCause = 5'd13;
    localparam logic [4:0] RegEpc   = 5'd14;
    localparam logic [4:0] RegPrid  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] victim_pc;

    assign int_pend  = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_pend  = (ExcCode_M != 5'd0) & ~exl_q;
    // Exception codes may still be arriving while reset is held; never request then.
    assign IntReq    = reset_n & (int_pend | exc_pend);
    assign victim_pc = BD_M ? (PC_M - 32'd4) : PC_M;
    assign EPC_out   = epc_q;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = HWInt;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (IntReq) begin
            // The victim does not commit, so a same-cycle mtc0/eret is dropped.
            exl_d      = 1'b1;
            exc_code_d = int_pend ? 5'd0 : ExcCode_M;
            bd_d       = BD_M;
            epc_d      = victim_pc & ~32'h0000_0003;
        end else begin
            if (we) begin
                case (A2)
                    RegSr: begin
                        im_d  = DIn[15:10];
                        exl_d = DIn[1];
                        ie_d  = DIn[0];
                    end
                    RegEpc:  epc_d = DIn;
                    default: ;
                endcase
            end
            // Placed after the mtc0 decode so eret wins on the EXL bit.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            RegSr:    DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
            RegCause: DOut = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
            RegEpc:   DOut = epc_q;
            RegPrid:  DOut = PRID_VALUE;
            default:  DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: one task per feature, inline comparisons.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h0000_2020;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  A1, A2, ExcCode_M;
    logic [31:0] DIn, PC_M;
    logic        we, BD_M, EXLClr;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [31:0] EPC_out, DOut;

    int checks = 0;
    int errors = 0;

    cp0_unit #(.PRID_VALUE(PRID)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .we        (we),
        .PC_M      (PC_M),
        .BD_M      (BD_M),
        .ExcCode_M (ExcCode_M),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .IntReq    (IntReq),
        .EPC_out   (EPC_out),
        .DOut      (DOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = '0; we = 1'b0; PC_M = '0;
        BD_M = 1'b0; ExcCode_M = 5'd12; HWInt = 6'h3F; EXLClr = 1'b0;
        #2;
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL reset_intreq: got %b expected 0", IntReq); end
        checks++; if (EPC_out !== 32'h0) begin errors++; $display("FAIL reset_epc_out: got %h expected 00000000", EPC_out); end
        A1 = 5'd12; #1;
        checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL reset_sr: got %h expected 00000000", DOut); end
        A1 = 5'd13; #1;
        checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h expected 00000000", DOut); end
        A1 = 5'd15; #1;
        checks++; if (DOut !== PRID) begin errors++; $display("FAIL reset_prid: got %h expected %h", DOut, PRID); end
        ExcCode_M = 5'd0; HWInt = 6'h0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_overflow();
        ExcCode_M = 5'd12; PC_M = 32'h0000_3010; BD_M = 1'b0; #1;
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL ov_intreq: got %b expected 1", IntReq); end
        tick();
        ExcCode_M = 5'd0; A1 = 5'd13; #1;
        checks++; if (DOut !== 32'h0000_0030) begin errors++; $display("FAIL ov_cause: got %h expected 00000030", DOut); end
        checks++; if (EPC_out !== 32'h0000_3010) begin errors++; $display("FAIL ov_epc: got %h expected 00003010", EPC_out); end
        A1 = 5'd12; #1;
        checks++; if (DOut !== 32'h0000_0002) begin errors++; $display("FAIL ov_sr: got %h expected 00000002", DOut); end
        ExcCode_M = 5'd4; #1;
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL ov_nested_masked: got %b expected 0", IntReq); end
        ExcCode_M = 5'd0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0; #1;
        checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL ov_eret_sr: got %h expected 00000000", DOut); end
    endtask

    task automatic test_delay_slot();
        ExcCode_M = 5'd4; PC_M = 32'h0000_3000; BD_M = 1'b1; #1;
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL bd_intreq: got %b expected 1", IntReq); end
        tick();
        ExcCode_M = 5'd0; BD_M = 1'b0; A1 = 5'd13; #1;
        checks++; if (EPC_out !== 32'h0000_2FFC) begin errors++; $display("FAIL bd_epc: got %h expected 00002ffc", EPC_out); end
        checks++; if (DOut !== 32'h8000_0010) begin errors++; $display("FAIL bd_cause: got %h expected 80000010", DOut); end
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        // Wrap: PC 0x2 in a delay slot gives 0xFFFF_FFFE, low bits forced clear.
        ExcCode_M = 5'd10; PC_M = 32'h0000_0002; BD_M = 1'b1;
        tick();
        ExcCode_M = 5'd0; BD_M = 1'b0; #1;
        checks++; if (EPC_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_epc: got %h expected fffffffc", EPC_out); end
        checks++; if (DOut !== 32'h8000_0028) begin errors++; $display("FAIL wrap_cause: got %h expected 80000028", DOut); end
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
    endtask

    task automatic test_int_vs_mtc0();
        we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        we = 1'b0; A1 = 5'd12; #1;
        checks++; if (DOut !== 32'h0000_0401) begin errors++; $display("FAIL im_sr_write: got %h expected 00000401", DOut); end
        HWInt = 6'b000001; we = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEC;
        PC_M = 32'h0000_4000; BD_M = 1'b0; #1;
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL int_intreq: got %b expected 1", IntReq); end
        tick();
        we = 1'b0; A1 = 5'd13; #1;
        checks++; if (EPC_out !== 32'h0000_4000) begin errors++; $display("FAIL int_epc: got %h expected 00004000", EPC_out); end
        checks++; if (DOut !== 32'h0000_0400) begin errors++; $display("FAIL int_cause: got %h expected 00000400", DOut); end
        A1 = 5'd12; #1;
        checks++; if (DOut !== 32'h0000_0403) begin errors++; $display("FAIL int_sr: got %h expected 00000403", DOut); end
    endtask

    task automatic test_eret_and_reset();
        #1;
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL exl_masks_int: got %b expected 0", IntReq); end
        EXLClr = 1'b1; #1;
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL eret_same_cycle: got %b expected 0", IntReq); end
        tick();
        EXLClr = 1'b0; #1;
        checks++; if (DOut !== 32'h0000_0401) begin errors++; $display("FAIL eret_sr: got %h expected 00000401", DOut); end
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL eret_reraise: got %b expected 1", IntReq); end
        tick();
        #1;
        checks++; if (DOut !== 32'h0000_0403) begin errors++; $display("FAIL reint_sr: got %h expected 00000403", DOut); end
        reset_n = 1'b0; #1;
        checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL async_rst_sr: got %h expected 00000000", DOut); end
        checks++; if (EPC_out !== 32'h0) begin errors++; $display("FAIL async_rst_epc: got %h expected 00000000", EPC_out); end
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL async_rst_intreq: got %b expected 0", IntReq); end
        A1 = 5'd13; #1;
        checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL async_rst_cause: got %h expected 00000000", DOut); end
        HWInt = 6'h0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_masking();
        HWInt = 6'h3F; #1;
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL mask_ie0: got %b expected 0", IntReq); end
        tick();
        A1 = 5'd13; #1;
        checks++; if (DOut !== 32'h0000_FC00) begin errors++; $display("FAIL mask_ip: got %h expected 0000fc00", DOut); end
        we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0001;
        tick();
        we = 1'b0; A1 = 5'd12; #1;
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL mask_im0: got %b expected 0", IntReq); end
        checks++; if (DOut !== 32'h0000_0001) begin errors++; $display("FAIL mask_sr: got %h expected 00000001", DOut); end
        HWInt = 6'h0; we = 1'b1; DIn = 32'h0;
        tick();
        we = 1'b0;
    endtask

    task automatic test_we_and_eret();
        we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0002;
        tick();
        A1 = 5'd12; DIn = 32'h0000_FC03; EXLClr = 1'b1; #1;
        checks++; if (DOut !== 32'h0000_0002) begin errors++; $display("FAIL exl_via_mtc0: got %h expected 00000002", DOut); end
        tick();
        we = 1'b0; EXLClr = 1'b0; #1;
        checks++; if (DOut !== 32'h0000_FC01) begin errors++; $display("FAIL eret_wins_exl: got %h expected 0000fc01", DOut); end
        we = 1'b1; DIn = 32'h0;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reads();
        A1 = 5'd15; #1;
        checks++; if (DOut !== PRID) begin errors++; $display("FAIL read_prid: got %h expected %h", DOut, PRID); end
        A1 = 5'd7; #1;
        checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL read_unmapped: got %h expected 00000000", DOut); end
        we = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        A2 = 5'd15; A1 = 5'd13; #1;
        checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL cause_ro: got %h expected 00000000", DOut); end
        tick();
        A1 = 5'd15; A2 = 5'd14; DIn = 32'h1234_5678; #1;
        checks++; if (DOut !== PRID) begin errors++; $display("FAIL prid_ro: got %h expected %h", DOut, PRID); end
        A1 = 5'd14; #1;
        checks++; if (DOut !== 32'h0) begin errors++; $display("FAIL no_bypass: got %h expected 00000000", DOut); end
        tick();
        we = 1'b0; #1;
        checks++; if (EPC_out !== 32'h1234_5678) begin errors++; $display("FAIL mtc0_epc: got %h expected 12345678", EPC_out); end
        checks++; if (DOut !== 32'h1234_5678) begin errors++; $display("FAIL mfc0_epc: got %h expected 12345678", DOut); end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_delay_slot();
        test_int_vs_mtc0();
        test_eret_and_reset();
        test_masking();
        test_we_and_eret();
        test_reads();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
